// File: rtl/rv_types.sv
// Shared types for the RV timer block.
// Contents:
//   ADR_*        register byte offsets within the 32-byte window
//   tmr_state_e  timer FSM state encoding
//   apply_be     merges write data into an old word, one byte lane per enable
package rv_types;

  localparam logic [4:0] ADR_CTRL   = 5'h00;
  localparam logic [4:0] ADR_COUNT  = 5'h04;
  localparam logic [4:0] ADR_RELOAD = 5'h08;
  localparam logic [4:0] ADR_STATUS = 5'h0C;
  localparam logic [4:0] ADR_PRESC  = 5'h10;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_e;

  // Byte-lane merge: be[b] selects bits 8*b+7 : 8*b from new_v.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_tmr_presc.sv
// Prescaler for the RV timer: counts cycles while enabled and pulses tick
// when the counter matches the programmed prescale value.
// Ports:
//   clk, xreset  clock, asynchronous active-low reset
//   en_i         counter advances only while high (timer in RUN)
//   clr_i        restart the counter at 0 (prescale value being rewritten)
//   presc_i      prescale value; 0 gives a tick every enabled cycle
//   tick_o       one-cycle tick, combinational from the counter register
module rv_tmr_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               xreset,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic               match_s;

  assign match_s = (cnt_q == presc_i);
  assign tick_o  = en_i & match_s;

  // Prescaler counter: wraps to 0 on a match, holds while disabled.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (match_s) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PRESC_W'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/rv_tmr.sv
// RV memory-mapped down-counting timer with prescaler, auto-reload and
// a level interrupt.
// Ports:
//   clk, xreset   clock, asynchronous active-low reset
//   adr, cs, rdy  byte offset, window select, bus ready
//   we, re, dw    per-byte write enable, read enable, write data
//   dr            read data, registered, 0 when no read was accepted
//   irq           flag & irq_en
module rv_tmr
  import rv_types::*;
#(
  parameter int          PRESC_W    = 16,
  parameter logic [31:0] RST_RELOAD = 32'hffffffff
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        irq
);

  tmr_state_e         state_q, state_d;
  logic [31:0]        count_q, count_d;
  logic               flag_q, flag_d;
  logic               irq_en_q, reload_en_q;
  logic [31:0]        reload_q;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic        wr_s, rd_s, tick_s, expire_s;
  logic        wr_ctrl_s, wr_count_s, wr_reload_s, wr_status_s, wr_presc_s;
  logic        run_wr1_s, run_wr0_s;
  logic [31:0] rdata_s, presc_ext_s;

  rv_tmr_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .xreset  (xreset),
    .en_i    (state_q == ST_RUN),
    .clr_i   (wr_presc_s),
    .presc_i (presc_q),
    .tick_o  (tick_s)
  );

  // Bus decode and FSM/count/flag next-state.
  always_comb begin
    wr_s        = cs & rdy & (we != 4'b0000);
    rd_s        = cs & rdy & re;
    wr_ctrl_s   = wr_s & (adr == ADR_CTRL);
    wr_count_s  = wr_s & (adr == ADR_COUNT);
    wr_reload_s = wr_s & (adr == ADR_RELOAD);
    wr_status_s = wr_s & (adr == ADR_STATUS);
    wr_presc_s  = wr_s & (adr == ADR_PRESC);
    run_wr1_s   = wr_ctrl_s & we[0] & dw[0];
    run_wr0_s   = wr_ctrl_s & we[0] & ~dw[0];
    expire_s    = (state_q == ST_RUN) & tick_s & (count_q == 32'd0);

    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (run_wr1_s) state_d = ST_RUN;
        else           state_d = ST_STOP;
      end
      ST_RUN: begin
        if (run_wr0_s)                     state_d = ST_STOP;
        else if (expire_s && !reload_en_q) state_d = ST_DONE;
        else                               state_d = ST_RUN;
      end
      ST_DONE: begin
        if (run_wr1_s)      state_d = ST_RUN;
        else if (run_wr0_s) state_d = ST_STOP;
        else                state_d = ST_DONE;
      end
      default: state_d = ST_STOP;
    endcase

    // A software COUNT write beats both the restart load and the tick.
    count_d = count_q;
    if (wr_count_s) begin
      count_d = apply_be(count_q, dw, we);
    end else if ((state_q == ST_DONE) && run_wr1_s) begin
      count_d = reload_q;
    end else if ((state_q == ST_RUN) && tick_s) begin
      if (count_q == 32'd0) begin
        count_d = reload_en_q ? reload_q : 32'd0;
      end else begin
        count_d = count_q - 32'd1;
      end
    end else begin
      count_d = count_q;
    end

    // Expiry wins over a same-cycle software clear.
    if (expire_s) begin
      flag_d = 1'b1;
    end else if (wr_status_s && we[0] && dw[0]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // PRESC byte-lane merge and read-data mux.
  always_comb begin
    presc_d = presc_q;
    for (int i = 0; i < PRESC_W; i++) begin
      if (we[i/8]) presc_d[i] = dw[i];
      else         presc_d[i] = presc_q[i];
    end
    presc_ext_s = 32'd0;
    presc_ext_s[PRESC_W-1:0] = presc_q;
    case (adr)
      ADR_CTRL:   rdata_s = {29'd0, reload_en_q, irq_en_q, (state_q == ST_RUN)};
      ADR_COUNT:  rdata_s = count_q;
      ADR_RELOAD: rdata_s = reload_q;
      ADR_STATUS: rdata_s = {31'd0, flag_q};
      ADR_PRESC:  rdata_s = presc_ext_s;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Timer FSM, COUNT and STATUS flag.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q <= ST_STOP;
      count_q <= 32'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  // Configuration registers and registered read data.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      irq_en_q    <= 1'b0;
      reload_en_q <= 1'b0;
      reload_q    <= RST_RELOAD;
      presc_q     <= '0;
      dr          <= 32'd0;
    end else begin
      if (wr_ctrl_s && we[0]) begin
        irq_en_q    <= dw[1];
        reload_en_q <= dw[2];
      end
      if (wr_reload_s) reload_q <= apply_be(reload_q, dw, we);
      if (wr_presc_s)  presc_q  <= presc_d;
      dr <= rd_s ? rdata_s : 32'd0;
    end
  end

  assign irq = flag_q & irq_en_q;

endmodule

// File: tb/tb_rv_tmr.sv
// Self-checking bench for rv_tmr. Reads push their expected value onto a
// scoreboard queue; a negedge monitor pops and compares when dr is valid.
module tb_rv_tmr;
  import rv_types::*;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic [4:0]  adr = 5'd0;
  logic        cs = 1'b0;
  logic        rdy = 1'b0;
  logic [3:0]  we = 4'd0;
  logic        re = 1'b0;
  logic [31:0] dw = 32'd0;
  logic [31:0] dr;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_acc_r = 1'b0;

  rv_tmr #(.PRESC_W(16), .RST_RELOAD(32'hffffffff)) dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy),
    .we(we), .re(re), .dw(dw), .dr(dr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remember which edges captured an accepted read.
  always @(posedge clk) rd_acc_r <= cs & rdy & re;

  // Scoreboard compare: dr is valid in the cycle after an accepted read.
  always @(negedge clk) begin
    if (rd_acc_r) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", dr, 32'hdeadbeef);
      end else begin
        check_val(tag_q.pop_front(), dr, exp_q.pop_front());
      end
    end
  end

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    adr = a; dw = d; we = 4'hf; cs = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; we = 4'h0; rdy = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp,
                        input string tag);
    adr = a; cs = 1'b1; rdy = 1'b1; re = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    cs = 1'b0; re = 1'b0; rdy = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    cycles(3);
    #2 xreset = 1'b1;
    cycles(1);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    bus_rd(ADR_CTRL,   32'd0,        "rst_ctrl");
    bus_rd(ADR_COUNT,  32'd0,        "rst_count");
    bus_rd(ADR_RELOAD, 32'hffffffff, "rst_reload");
    bus_rd(ADR_STATUS, 32'd0,        "rst_status");
    bus_rd(ADR_PRESC,  32'd0,        "rst_presc");
    bus_rd(5'h14,      32'd0,        "unmapped");
    cycles(2);
    check_val("dr_idle", dr, 32'd0);

    // Auto-reload, PRESC=0: expiry on the 4th tick, period 4
    bus_wr(ADR_PRESC, 32'd0);
    bus_wr(ADR_RELOAD, 32'd3);
    bus_wr(ADR_COUNT, 32'd3);
    bus_wr(ADR_CTRL, 32'd7);
    cycles(3);
    check_val("ar_irq_pre", {31'd0, irq}, 32'd0);
    cycles(1);
    check_val("ar_irq_set", {31'd0, irq}, 32'd1);
    bus_rd(ADR_COUNT, 32'd3, "ar_count_reload");
    bus_wr(ADR_STATUS, 32'd1);
    check_val("ar_irq_clr", {31'd0, irq}, 32'd0);
    cycles(1);
    check_val("ar_irq_pre2", {31'd0, irq}, 32'd0);
    cycles(1);
    check_val("ar_irq_rep", {31'd0, irq}, 32'd1);
    bus_wr(ADR_CTRL, 32'd0);
    bus_wr(ADR_STATUS, 32'd1);

    // One-shot, PRESC=1, COUNT=2: expiry 6 cycles after run
    bus_wr(ADR_COUNT, 32'd2);
    bus_wr(ADR_PRESC, 32'd1);
    bus_wr(ADR_CTRL, 32'd3);
    cycles(5);
    check_val("os_irq_pre", {31'd0, irq}, 32'd0);
    cycles(1);
    check_val("os_irq_set", {31'd0, irq}, 32'd1);
    bus_rd(ADR_CTRL,   32'd2, "os_ctrl_run0");
    bus_rd(ADR_COUNT,  32'd0, "os_count_hold");
    bus_rd(ADR_STATUS, 32'd1, "os_flag");

    // Flag set beats a same-cycle clear; a later clear drops irq
    bus_wr(ADR_STATUS, 32'd1);
    bus_wr(ADR_PRESC, 32'd0);
    bus_wr(ADR_RELOAD, 32'd1);
    bus_wr(ADR_COUNT, 32'd1);
    bus_wr(ADR_CTRL, 32'd7);
    cycles(1);
    bus_wr(ADR_STATUS, 32'd1);
    check_val("pri_flag_stays", {31'd0, irq}, 32'd1);
    bus_wr(ADR_STATUS, 32'd1);
    check_val("pri_irq_drop", {31'd0, irq}, 32'd0);
    bus_wr(ADR_CTRL, 32'd0);
    bus_wr(ADR_STATUS, 32'd1);

    // COUNT write beats a same-cycle tick decrement
    bus_wr(ADR_RELOAD, 32'd1000);
    bus_wr(ADR_COUNT, 32'd50);
    bus_wr(ADR_CTRL, 32'd5);
    bus_wr(ADR_COUNT, 32'd100);
    bus_rd(ADR_COUNT, 32'd100, "cw_priority");
    bus_rd(ADR_COUNT, 32'd99,  "cw_decrement");
    bus_wr(ADR_CTRL, 32'd0);

    // Reset mid-count abandons the count
    bus_wr(ADR_RELOAD, 32'd5);
    bus_wr(ADR_COUNT, 32'd1);
    bus_wr(ADR_CTRL, 32'd3);
    xreset = 1'b0;
    #2 xreset = 1'b1;
    cycles(4);
    check_val("mr_irq", {31'd0, irq}, 32'd0);
    bus_rd(ADR_CTRL,   32'd0,        "mr_ctrl");
    bus_rd(ADR_COUNT,  32'd0,        "mr_count");
    bus_rd(ADR_RELOAD, 32'hffffffff, "mr_reload");
    bus_rd(ADR_STATUS, 32'd0,        "mr_status");
    bus_rd(ADR_PRESC,  32'd0,        "mr_presc");

    cycles(2);
    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_tmr.md
RV_TMR -- requirements
Module: rv_tmr

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, prescaler register width in bits (range 1..32).
REQ-002 SHALL have parameter RST_RELOAD, default 32'hffffffff, reset value of RELOAD.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port xreset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port adr, input, 5, byte offset within the 32-byte window (d_adr[4:0]).
REQ-006 SHALL have port cs, input, 1, window select, decoded externally for base ffff0040.
REQ-007 SHALL have port rdy, input, 1, bus ready; reads and writes are qualified by rdy.
REQ-008 SHALL have port we, input, 4, per-byte write enable; we[0] selects bits 7:0.
REQ-009 SHALL have port re, input, 1, read enable.
REQ-010 SHALL have port dw, input, 32, write data.
REQ-011 SHALL have port dr, output, 32, registered read data.
REQ-012 SHALL have port irq, output, 1, level interrupt request to the core.

Function
REQ-013 SHALL map registers: 00 CTRL[2:0] = {reload_en, irq_en, run}; 04 COUNT; 08 RELOAD; 0C STATUS[0] = flag; 10 PRESC[PRESC_W-1:0]; other offsets read 0, writes ignored.
REQ-014 SHALL perform a write when cs & rdy & we != 0, byte lanes per we, effective on the next edge.
REQ-015 SHALL register dr one cycle after cs & rdy & re, and hold dr at 0 in cycles without an accepted read.
REQ-016 SHALL clear STATUS.flag when a write has we[0] & dw[0]; a write with dw[0] = 0 has no effect on the flag.
REQ-017 SHALL derive tick when the prescaler counter equals PRESC; the counter then returns to 0, otherwise it increments; the counter runs only in RUN.
REQ-018 SHALL make PRESC = 0 produce a tick every cycle.
REQ-019 SHALL implement the FSM STOP -> RUN on a CTRL.run write of 1; any -> STOP on a CTRL.run write of 0; RUN -> DONE on expiry with reload_en = 0; DONE -> RUN on a CTRL.run write of 1, which also loads COUNT from RELOAD.
REQ-020 SHALL decrement COUNT on a tick in RUN; a tick with COUNT = 0 is expiry: set the flag, and load COUNT from RELOAD if reload_en = 1, else hold 0 and enter DONE.
REQ-021 SHALL wrap-free count: COUNT never decrements below 0; RELOAD = 0 with reload_en = 1 expires on every tick.
REQ-022 SHALL reflect the FSM state in CTRL.run on read: 1 in RUN, 0 in STOP and DONE.
REQ-023 SHALL drive irq = flag & irq_en, combinationally from registers, with no added latency.
REQ-024 SHALL give a software COUNT write priority over a same-cycle decrement or reload.
REQ-025 SHALL give flag set priority over a same-cycle clear, so the flag stays 1.
REQ-026 SHALL apply a PRESC write immediately and reset the prescaler counter to 0.

Reset
REQ-027 SHALL, on xreset low and asynchronously, set: FSM STOP; CTRL 0; COUNT 0; RELOAD RST_RELOAD; PRESC 0; prescaler counter 0; flag 0; dr 0; irq 0.
REQ-028 SHALL, on reset assertion mid-count, abandon the count with no expiry and no flag.

Structure
REQ-029 SHALL take register offsets and the FSM state enum from the shared rv_types package.
REQ-030 SHALL contain one sub-module, rv_tmr_presc, holding the prescaler counter and tick generation.

Verification
REQ-031 SHALL cover: reset, then read offsets 00/04/08/0C/10 -> 0, 0, ffffffff, 0, 0 one cycle after re.
REQ-032 SHALL cover: PRESC = 0, RELOAD = 3, COUNT = 3, CTRL = 7 -> flag and irq at the 4th tick after run, COUNT back to 3, repeating every 4 cycles.
REQ-033 SHALL cover: CTRL = 3 (one-shot), COUNT = 2, PRESC = 1 -> expiry after 6 cycles, CTRL.run reads 0, COUNT holds 0, irq = 1.
REQ-034 SHALL cover: a STATUS write of 1 on the same cycle as an expiry -> flag stays 1; a STATUS write of 1 the next cycle -> irq drops the following cycle.
REQ-035 SHALL cover: a COUNT write of 100 coinciding with a tick -> COUNT reads 100, not 99.
REQ-036 SHALL cover: xreset pulsed low with COUNT = 1 while running -> no flag set, all registers at their reset values.
